// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts, optional shift-add multiplier.
// Define ALU_MUL_EN to compile in the MUL state and opcode 1000; otherwise 1000 is illegal.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] inp1,
  input  logic signed [WIDTH-1:0] inp2,
  input  logic        [SHW-1:0]   shamt,
  input  logic        [3:0]       ALUControl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out,
  output logic                    carry_out,
  output logic                    isNeg,
  output logic                    isZero
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_COMP = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SLAI = 4'b0100;
  localparam logic [3:0] OP_SRAI = 4'b0101;
  localparam logic [3:0] OP_SRLI = 4'b0110;
  localparam logic [3:0] OP_SLAR = 4'b1100;
  localparam logic [3:0] OP_SRAR = 4'b1101;
  localparam logic [3:0] OP_SRLR = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1000;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       sht_q, sht_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mstep;
`endif

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sstep;
  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;

  // Type encoding follows ALUControl[1:0]: 00 SLA, 01 SRA, 10 SRL.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] t);
    case (t)
      2'b00:   shift1 = {v[WIDTH-2:0], 1'b0};
      2'b01:   shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift1 = {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    sht_d     = sht_q;
    res_d     = res_q;
    carry_d   = carry_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mstep     = mplier_q[0] ? (work_q + mcand_q) : work_q;
`endif
    fin       = 1'b0;
    fin_res   = '0;
    fin_carry = 1'b0;

    add_w = {1'b0, inp1} + {1'b0, inp2};
    sub_w = {1'b0, inp1} + {1'b0, ~inp2} + {{WIDTH{1'b0}}, 1'b1};
    amt   = ALUControl[3] ? inp2[SHW-1:0] : shamt;
    sstep = shift1(work_q, sht_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (ALUControl)
            OP_ADD:  begin fin = 1'b1; fin_res = add_w[WIDTH-1:0]; fin_carry = add_w[WIDTH]; end
            OP_COMP: begin fin = 1'b1; fin_res = -inp2; end
            OP_AND:  begin fin = 1'b1; fin_res = inp1 & inp2; end
            OP_XOR:  begin fin = 1'b1; fin_res = inp1 ^ inp2; end
            OP_SUB:  begin fin = 1'b1; fin_res = sub_w[WIDTH-1:0]; fin_carry = sub_w[WIDTH]; end
            OP_SLAI, OP_SRAI, OP_SRLI, OP_SLAR, OP_SRAR, OP_SRLR: begin
              sht_d = ALUControl[1:0];
              if (amt == '0) begin
                fin     = 1'b1;
                fin_res = inp1;
              end else begin
                work_d  = inp1;
                cnt_d   = {1'b0, amt};
                state_d = SHIFT;
              end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              work_d   = '0;
              mcand_d  = inp1;
              mplier_d = inp2;
              cnt_d    = CW'(WIDTH);
              state_d  = MUL;
            end
`endif
            default: begin fin = 1'b1; fin_res = '0; end
          endcase
        end
      end
      // The last step writes the result directly so latency is k+1 edges.
      SHIFT: begin
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          fin_res = sstep;
        end else begin
          work_d = sstep;
          cnt_d  = cnt_q - CW'(1);
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          fin_res = mstep;
        end else begin
          work_d   = mstep;
          mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q - CW'(1);
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      res_d   = fin_res;
      carry_d = fin_carry;
      neg_d   = fin_res[WIDTH-1];
      zero_d  = (fin_res == '0);
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      sht_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sht_q    <= sht_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = res_q;
  assign carry_out = carry_q;
  assign isNeg     = neg_q;
  assign isZero    = zero_q;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two >= 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL be derived from WIDTH and not overridden.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-007 inp1, inp2  input  WIDTH each  signed operands.
REQ-008 shamt  input  SHW  immediate shift amount.
REQ-009 ALUControl  input  4  operation select.
REQ-010 out_valid  output  1  result valid; held until accepted.
REQ-011 out_ready  input  1  result accepted when out_valid && out_ready at a rising edge.
REQ-012 out  output  WIDTH  registered signed result.
REQ-013 carry_out, isNeg, isZero  output  1 each  registered flags for out.

Function
REQ-014 Opcodes SHALL be: 0000 ADD, 0001 COMP (-inp2), 0010 AND, 0011 XOR, 0111 SUB (inp1-inp2), 0100 SLA by shamt, 0101 SRA by shamt, 0110 SRL by shamt, 1100 SLA by inp2[SHW-1:0], 1101 SRA by inp2[SHW-1:0], 1110 SRL by inp2[SHW-1:0], 1000 MUL (low WIDTH bits, signed).
REQ-015 FSM states SHALL be IDLE, SHIFT, MUL, DONE; in_ready SHALL equal (state == IDLE).
REQ-016 ADD, COMP, AND, XOR, SUB, illegal opcodes: IDLE -> DONE on accept; out_valid high after exactly 1 edge.
REQ-017 Shifts: operand and amount k latched on accept; k == 0 SHALL go IDLE -> DONE (latency 1); k >= 1 SHALL go to SHIFT, shift one bit per cycle, enter DONE so out_valid rises exactly k+1 edges after accept.
REQ-018 SRA SHALL replicate the sign bit; SRL and SLA SHALL fill zeros.
REQ-019 MUL SHALL run shift-add for WIDTH cycles in MUL state; out_valid rises exactly WIDTH+1 edges after accept.
REQ-020 DONE SHALL hold out and flags stable while out_ready is low; on out_ready high, next state IDLE and out_valid low.
REQ-021 A new request SHALL NOT be accepted in the same edge a result is consumed (no bypass).
REQ-022 carry_out SHALL be bit WIDTH of inp1+inp2 (ADD) or inp1+~inp2+1 (SUB); 0 for all other ops.
REQ-023 isZero SHALL be (out == 0); isNeg SHALL be out[WIDTH-1]; both updated with out.
REQ-024 Illegal opcodes SHALL produce out=0, carry_out=0, isZero=1, isNeg=0.
REQ-025 Inputs SHALL be ignored outside the accept edge; changes during SHIFT/MUL SHALL not affect the result.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid=0, out=0, carry_out=0, isNeg=0, isZero=0, and clear all internal counters/operand registers.
REQ-027 Reset mid-SHIFT/MUL SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-028 First request SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_MUL_EN: defined -> MUL state and shift-add datapath compiled in, opcode 1000 per REQ-019.
REQ-030 ALU_MUL_EN undefined -> no MUL state or multiplier logic; opcode 1000 SHALL behave as illegal per REQ-024 with latency 1.

Verification (WIDTH=32)
REQ-031 ADD 200+169, out_ready=1 -> out=369, carry_out=0, isZero=0, out_valid 1 edge after accept.
REQ-032 ADD 32'hFFFFFFFF+1 -> out=0, carry_out=1, isZero=1; SUB 111-111 -> out=0, isZero=1, carry_out=1.
REQ-033 SRA inp1=-111, shamt=4 -> out=-7, isNeg=1, out_valid exactly 5 edges after accept; in_ready low throughout.
REQ-034 SUB 200-169 with out_ready low 3 cycles -> out=31 held stable, in_ready=0, single consumption when out_ready rises.
REQ-035 MUL 200*3: with ALU_MUL_EN -> out=600 after 33 edges; without -> out=0, isZero=1 after 1 edge.
REQ-036 rst_n pulsed low during SRL by inp2=20 -> all outputs 0 at once, no out_valid, next request accepted normally.
